// File: rtl/sound_priority_arbiter.sv
// Sound-track arbiter: picks between prioritised game sound events and the
// background soundtrack, and drives the player's track select and restart strobe.
module sound_priority_arbiter #(
  parameter int                NUM_CH       = 4,
  parameter int                SEL_W        = 4,
  parameter logic [NUM_CH-1:0] ONESHOT_MASK = 4'b0111,
  parameter bit                PEND_EN      = 1'b1,
  parameter bit                RETRIGGER    = 1'b1,
  parameter int                Y_W          = 10,
  parameter int                BG_THRESHOLD = 256,
  localparam int               AW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] kill,
  input  logic              track_ended,
  input  logic [Y_W-1:0]    level_y,
  output logic [SEL_W-1:0]  select,
  output logic              new_trackN,
  output logic              busy,
  output logic [AW-1:0]     active_ch
);

  localparam logic [SEL_W-1:0] SEL_SILENCE = SEL_W'(NUM_CH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BG, ST_PLAY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cur_q, cur_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] cand, cand_x, cur_oh, latch;
  logic              win_any, winx_any;
  logic [AW-1:0]     win_idx, winx_idx;
  logic              bg_on, ended, restart;
  logic [SEL_W-1:0]  sel_d;

  // Candidate sets and their highest-priority members; cand_x excludes the
  // playing channel so a channel that just ended cannot re-grant itself.
  always_comb begin
    cur_oh   = NUM_CH'(1) << cur_q;
    cand     = req | pend_q;
    cand_x   = cand & ~cur_oh;
    win_any  = 1'b0;
    win_idx  = '0;
    winx_any = 1'b0;
    winx_idx = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (cand[i-1]) begin
        win_any = 1'b1;
        win_idx = AW'(i - 1);
      end
      if (cand_x[i-1]) begin
        winx_any = 1'b1;
        winx_idx = AW'(i - 1);
      end
    end
    bg_on = 32'(level_y) >= 32'(BG_THRESHOLD);
    ended = ONESHOT_MASK[cur_q] ? track_ended : (kill[cur_q] | ~req[cur_q]);
  end

  // Next-state, pending-latch and next-select decision.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    restart = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_BG: begin
          if (win_any) begin
            state_d = ST_PLAY;
            cur_d   = win_idx;
          end else begin
            state_d = bg_on ? ST_BG : ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (win_any && (win_idx < cur_q)) begin
            cur_d = win_idx;
          end else if (ended) begin
            if (winx_any) begin
              cur_d = winx_idx;
            end else begin
              state_d = bg_on ? ST_BG : ST_IDLE;
            end
          end else if (RETRIGGER && ONESHOT_MASK[cur_q] && req[cur_q]) begin
            restart = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d != ST_PLAY) cur_d = '0;

    // Requests on the playing channel are never latched (retrigger or drop).
    latch = req & ONESHOT_MASK;
    if (state_q == ST_PLAY) latch = latch & ~cur_oh;
    pend_d = pend_q | latch;
    if (state_d == ST_PLAY) pend_d = pend_d & ~(NUM_CH'(1) << cur_d);
    if (!enable || !PEND_EN) pend_d = '0;

    unique case (state_d)
      ST_BG:   sel_d = '0;
      ST_PLAY: sel_d = SEL_W'(cur_d) + SEL_W'(1);
      default: sel_d = SEL_SILENCE;
    endcase
  end

  // State, pending flags and registered player outputs.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      pend_q     <= '0;
      select     <= SEL_SILENCE;
      new_trackN <= 1'b1;
      busy       <= 1'b0;
      active_ch  <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      select     <= sel_d;
      new_trackN <= ~((sel_d != select) | restart);
      busy       <= (state_d == ST_PLAY);
      active_ch  <= cur_d;
    end
  end

endmodule

// File: tb/tb_sound_priority_arbiter.sv
// Bench for sound_priority_arbiter: directed scenarios on a default instance and
// a no-pending/no-retrigger instance, then random traffic against a model.
module tb_sound_priority_arbiter;

  localparam bit [3:0] OS = 4'b0111;

  logic       MCLK = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] kill = '0;
  logic       track_ended = 1'b0;
  logic [9:0] level_y = 10'd100;

  logic [3:0] sel0, sel1;
  logic       ntn0, ntn1, busy0, busy1;
  logic [1:0] ach0, ach1;

  int errors = 0;
  int checks = 0;

  // Reference model state: mode 0=idle 1=background 2=playing
  int       m_mode, m_cur;
  bit [3:0] m_pend;
  int       e_sel, e_ach;
  bit       e_ntn, e_busy;

  always #5 MCLK = ~MCLK;

  sound_priority_arbiter u0 (
    .MCLK(MCLK), .reset(reset), .enable(enable), .req(req), .kill(kill),
    .track_ended(track_ended), .level_y(level_y),
    .select(sel0), .new_trackN(ntn0), .busy(busy0), .active_ch(ach0)
  );

  sound_priority_arbiter #(.PEND_EN(1'b0), .RETRIGGER(1'b0)) u1 (
    .MCLK(MCLK), .reset(reset), .enable(enable), .req(req), .kill(kill),
    .track_ended(track_ended), .level_y(level_y),
    .select(sel1), .new_trackN(ntn1), .busy(busy1), .active_ch(ach1)
  );

  function automatic int pick(bit [3:0] c, int skip);
    for (int i = 0; i < 4; i++)
      if (c[i] && i != skip) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_pend = '0;
    e_sel = 5; e_ntn = 1'b1; e_busy = 1'b0; e_ach = 0;
  endtask

  task automatic model_step();
    bit [3:0] cand;
    int       w, nm, nc, nsel;
    bit       fin, restart;
    cand = req | m_pend;
    nm = m_mode; nc = m_cur; restart = 0;
    if (!enable) begin
      nm = 0;
    end else if (m_mode != 2) begin
      w = pick(cand, -1);
      if (w >= 0) begin nm = 2; nc = w; end
      else nm = (level_y >= 256) ? 1 : 0;
    end else begin
      w = pick(cand, -1);
      fin = OS[m_cur] ? track_ended : (kill[m_cur] || !req[m_cur]);
      if (w >= 0 && w < m_cur) nc = w;
      else if (fin) begin
        w = pick(cand, m_cur);
        if (w >= 0) nc = w;
        else nm = (level_y >= 256) ? 1 : 0;
      end else if (OS[m_cur] && req[m_cur]) restart = 1;
    end
    if (!enable) m_pend = '0;
    else begin
      for (int i = 0; i < 4; i++)
        if (OS[i] && req[i] && !(m_mode == 2 && i == m_cur)) m_pend[i] = 1'b1;
      if (nm == 2) m_pend[nc] = 1'b0;
    end
    nsel = (nm == 2) ? nc + 1 : (nm == 1) ? 0 : 5;
    e_ntn = !((nsel != e_sel) || restart);
    e_sel = nsel;
    e_busy = (nm == 2);
    e_ach = (nm == 2) ? nc : 0;
    m_mode = nm;
    m_cur = (nm == 2) ? nc : 0;
  endtask

  task automatic tick();
    if (reset) model_reset();
    else model_step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (sel0 !== 4'd5) begin errors++; $display("FAIL reset_sel got=%0d exp=5", sel0); end
    checks++; if (ntn0 !== 1'b1) begin errors++; $display("FAIL reset_ntn got=%0b exp=1", ntn0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy0); end
    checks++; if (ach0 !== 2'd0) begin errors++; $display("FAIL reset_ach got=%0d exp=0", ach0); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_oneshot();
    req = 4'b0010; tick(); req = '0;
    checks++; if (sel0 !== 4'd2) begin errors++; $display("FAIL oneshot_sel got=%0d exp=2", sel0); end
    checks++; if (ntn0 !== 1'b0) begin errors++; $display("FAIL oneshot_strobe got=%0b exp=0", ntn0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL oneshot_busy got=%0b exp=1", busy0); end
    checks++; if (ach0 !== 2'd1) begin errors++; $display("FAIL oneshot_ach got=%0d exp=1", ach0); end
    tick();
    checks++; if (ntn0 !== 1'b1) begin errors++; $display("FAIL oneshot_strobe_len got=%0b exp=1", ntn0); end
    track_ended = 1'b1; tick(); track_ended = 1'b0;
    checks++; if (sel0 !== 4'd5) begin errors++; $display("FAIL oneshot_end_sel got=%0d exp=5", sel0); end
    checks++; if (ntn0 !== 1'b0) begin errors++; $display("FAIL oneshot_end_strobe got=%0b exp=0", ntn0); end
    tick();
    checks++; if (ntn0 !== 1'b1) begin errors++; $display("FAIL oneshot_idle_ntn got=%0b exp=1", ntn0); end
  endtask

  task automatic test_preempt();
    req = 4'b0100; tick();
    req = 4'b0001; tick(); req = '0;
    checks++; if (sel0 !== 4'd1) begin errors++; $display("FAIL preempt_sel got=%0d exp=1", sel0); end
    track_ended = 1'b1; tick(); track_ended = 1'b0;
    checks++; if (sel0 !== 4'd5) begin errors++; $display("FAIL preempt_noresume got=%0d exp=5", sel0); end
    tick();
  endtask

  task automatic test_pending();
    req = 4'b0001; tick();
    req = 4'b0100; tick(); req = '0;
    checks++; if (sel0 !== 4'd1) begin errors++; $display("FAIL pend_hold_sel got=%0d exp=1", sel0); end
    track_ended = 1'b1; tick();
    checks++; if (sel0 !== 4'd3) begin errors++; $display("FAIL pend_grant_sel got=%0d exp=3", sel0); end
    checks++; if (sel1 !== 4'd5) begin errors++; $display("FAIL nopend_sel got=%0d exp=5", sel1); end
    tick(); track_ended = 1'b0;
    checks++; if (sel0 !== 4'd5) begin errors++; $display("FAIL pend_end_sel got=%0d exp=5", sel0); end
    tick();
  endtask

  task automatic test_sustained();
    level_y = 10'd300; req = 4'b1000; tick();
    checks++; if (sel0 !== 4'd4) begin errors++; $display("FAIL sust_sel got=%0d exp=4", sel0); end
    tick();
    checks++; if (sel0 !== 4'd4 || ntn0 !== 1'b1) begin errors++; $display("FAIL sust_hold got=%0d/%0b exp=4/1", sel0, ntn0); end
    kill = 4'b1000; tick(); kill = '0; req = '0;
    checks++; if (sel0 !== 4'd0) begin errors++; $display("FAIL sust_kill_bg got=%0d exp=0", sel0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL sust_kill_busy got=%0b exp=0", busy0); end
    tick();
    checks++; if (sel0 !== 4'd0) begin errors++; $display("FAIL bg_stay got=%0d exp=0", sel0); end
    level_y = 10'd255; tick();
    checks++; if (sel0 !== 4'd5) begin errors++; $display("FAIL bg_below got=%0d exp=5", sel0); end
    level_y = 10'd256; tick();
    checks++; if (sel0 !== 4'd0) begin errors++; $display("FAIL bg_equal got=%0d exp=0", sel0); end
    level_y = 10'd100; tick();
  endtask

  task automatic test_retrigger();
    req = 4'b0010; tick(); req = '0; tick();
    req = 4'b0010; tick(); req = '0;
    checks++; if (ntn0 !== 1'b0 || sel0 !== 4'd2) begin errors++; $display("FAIL retrig got=%0b/%0d exp=0/2", ntn0, sel0); end
    checks++; if (ntn1 !== 1'b1 || sel1 !== 4'd2) begin errors++; $display("FAIL noretrig got=%0b/%0d exp=1/2", ntn1, sel1); end
    tick();
    checks++; if (ntn0 !== 1'b1) begin errors++; $display("FAIL retrig_len got=%0b exp=1", ntn0); end
    track_ended = 1'b1; tick(); track_ended = 1'b0;
    checks++; if (sel0 !== 4'd5 || sel1 !== 4'd5) begin errors++; $display("FAIL retrig_end got=%0d/%0d exp=5/5", sel0, sel1); end
    tick();
  endtask

  task automatic test_back_to_back();
    req = 4'b1000; tick();
    req = 4'b1010; tick(); req = 4'b1000;
    checks++; if (sel0 !== 4'd2) begin errors++; $display("FAIL b2b_preempt got=%0d exp=2", sel0); end
    track_ended = 1'b1; tick(); track_ended = 1'b0;
    checks++; if (sel0 !== 4'd4 || ntn0 !== 1'b0) begin errors++; $display("FAIL b2b_direct got=%0d/%0b exp=4/0", sel0, ntn0); end
    req = '0; tick();
    checks++; if (sel0 !== 4'd5) begin errors++; $display("FAIL b2b_release got=%0d exp=5", sel0); end
    tick();
  endtask

  task automatic test_enable();
    req = 4'b0001; tick();
    req = 4'b0100; tick(); req = '0;
    enable = 1'b0; tick();
    checks++; if (sel0 !== 4'd5 || ntn0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL disable got=%0d/%0b/%0b exp=5/0/0", sel0, ntn0, busy0); end
    enable = 1'b1; tick();
    checks++; if (sel0 !== 4'd5 || ntn0 !== 1'b1) begin errors++; $display("FAIL reenable got=%0d/%0b exp=5/1", sel0, ntn0); end
    tick();
    checks++; if (sel0 !== 4'd5) begin errors++; $display("FAIL pend_cleared got=%0d exp=5", sel0); end
    req = 4'b0010; tick(); req = '0;
    #3; reset = 1'b1; #1;
    checks++; if (sel0 !== 4'd5 || ntn0 !== 1'b1 || busy0 !== 1'b0 || ach0 !== 2'd0) begin
      errors++; $display("FAIL async_reset got=%0d/%0b/%0b/%0d exp=5/1/0/0", sel0, ntn0, busy0, ach0);
    end
    model_reset();
    tick(); reset = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 24) != 0);
      for (int i = 0; i < 3; i++) req[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) req[3] = ~req[3];
      for (int i = 0; i < 4; i++) kill[i] = ($urandom_range(0, 11) == 0);
      track_ended = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: level_y = 10'd255;
        1: level_y = 10'd256;
        default: level_y = 10'($urandom_range(0, 1023));
      endcase
      tick();
      checks++; if (sel0 !== 4'(e_sel)) begin errors++; $display("FAIL rnd_sel cyc=%0d got=%0d exp=%0d", n, sel0, e_sel); end
      checks++; if (ntn0 !== e_ntn) begin errors++; $display("FAIL rnd_ntn cyc=%0d got=%0b exp=%0b", n, ntn0, e_ntn); end
      checks++; if (busy0 !== e_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", n, busy0, e_busy); end
      checks++; if (ach0 !== 2'(e_ach)) begin errors++; $display("FAIL rnd_ach cyc=%0d got=%0d exp=%0d", n, ach0, e_ach); end
    end
    req = '0; kill = '0; track_ended = 1'b0; enable = 1'b1; level_y = 10'd100;
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_oneshot();
    test_preempt();
    test_pending();
    test_sustained();
    test_retrigger();
    test_back_to_back();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
